// File: rtl/wave_display_mc_if.sv
// Sample-RAM read port and bank-swap handshake shared between the waveform
// renderer (master) and the sample writer / sample RAMs (slave).
interface wave_display_mc_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned DEPTH_LG = 8
);
  // {display_bank, column}; one address drives every channel's sample RAM
  logic [DEPTH_LG:0]          read_address;
  // Synchronous RAM data, one cycle after read_address; channel 0 in the LSBs
  logic [NUM_CH*SAMPLE_W-1:0] read_value;
  // Writer has filled the bank that is not on display
  logic                       buf_ready;
  // One-cycle pulse: banks swapped, writer may refill the other one
  logic                       buf_ack;

  modport master (
    output read_address,
    output buf_ack,
    input  read_value,
    input  buf_ready
  );

  modport slave (
    input  read_address,
    input  buf_ack,
    output read_value,
    output buf_ready
  );
endinterface

// File: rtl/wave_display_mc.sv
// wave_display_mc: multi-channel pipelined waveform renderer.
// Draws NUM_CH sample RAMs as connected traces inside a fixed window of the raster,
// and owns the double-buffer bank swap with the sample writer.
// Latency from x_i/y_i/valid_i to r/g/b/valid_pixel_o is 2 clocks.
// Build option: define GRID_WAVE_DISPLAY_EN to draw a grid behind the traces.
module wave_display_mc #(
  parameter int unsigned          NUM_CH     = 2,
  parameter int unsigned          SAMPLE_W   = 8,
  parameter int unsigned          DEPTH_LG   = 8,
  parameter logic [10:0]          X0         = 11'd256,
  parameter logic [9:0]           Y0         = 10'd0,
  // Channel 0 in the LSBs: trace 0 white, trace 1 green
  parameter logic [NUM_CH*24-1:0] CH_COLORS  = {24'h00FF00, 24'hFFFFFF},
  parameter logic [23:0]          GRID_COLOR = 24'h404040
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [10:0]             x_i,
  input  logic [9:0]              y_i,
  input  logic                    valid_i,
  input  logic                    frame_start_i,
  input  logic [NUM_CH-1:0]       ch_enable_i,
  wave_display_mc_if.master       bus,
  output logic                    valid_pixel_o,
  output logic [7:0]              r_o,
  output logic [7:0]              g_o,
  output logic [7:0]              b_o,
  output logic [7:0]              dropped_frames_o
);

  localparam int unsigned WinW = 2 ** (DEPTH_LG + 1);
  localparam int unsigned WinH = 2 ** (SAMPLE_W + 1);

  typedef enum logic [0:0] {StRun, StAck} state_e;

  // Bank-swap FSM state
  state_e     state_q, state_d;
  logic       bank_q, bank_d;
  logic       buf_ack_q, buf_ack_d;
  logic [7:0] dropped_q, dropped_d;

  // Stage 0: raster position decode
  logic [31:0]         x_rel, y_rel;
  logic                in_win;
  logic [DEPTH_LG-1:0] col;
  logic [SAMPLE_W-1:0] yc;

  // Stage 1: position delayed to line up with the RAM data
  logic                s1_win_q;
  logic                s1_first_q;
  logic [DEPTH_LG-1:0] s1_col_q;
  logic [SAMPLE_W-1:0] s1_yc_q;
  logic [DEPTH_LG-1:0] last_col_q;

  // Per-channel sample tracking
  logic [SAMPLE_W-1:0] cur      [NUM_CH];
  logic [SAMPLE_W-1:0] prev_eff [NUM_CH];
  logic [SAMPLE_W-1:0] sample_q [NUM_CH];
  logic [SAMPLE_W-1:0] prev_q   [NUM_CH];
  logic [SAMPLE_W-1:0] lo       [NUM_CH];
  logic [SAMPLE_W-1:0] hi       [NUM_CH];
  logic [NUM_CH-1:0]   hit;

  // Colour selection and output stage
  logic        grid_hit;
  logic [23:0] color_d;
  logic        valid_pixel_q;
  logic [23:0] rgb_q;

  // ---------------------------------------------------------------------------
  // Stage 0
  // ---------------------------------------------------------------------------

  // Window test and sample column; offsets are taken at full width before shifting
  always_comb begin
    x_rel  = 32'(x_i) - 32'(X0);
    y_rel  = 32'(y_i) - 32'(Y0);
    in_win = valid_i && (x_i >= X0) && (x_rel < WinW) && (y_i >= Y0) && (y_rel < WinH);
    // Column parks at 0 outside the window; reads there are discarded
    col    = in_win ? x_rel[DEPTH_LG:1] : '0;
    yc     = y_rel[SAMPLE_W:1];
  end

  assign bus.read_address = {bank_q, col};

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------

  // Delay the decoded position by one cycle to meet the synchronous RAM data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_win_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_col_q   <= '0;
      s1_yc_q    <= '0;
    end else begin
      s1_win_q   <= in_win;
      s1_first_q <= in_win && (col == '0);
      s1_col_q   <= col;
      s1_yc_q    <= yc;
    end
  end

  // Choose each channel's segment start: the previous column's sample, or the current
  // sample on the first column so a line never joins the end of the line above
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cur[c] = bus.read_value[c*SAMPLE_W +: SAMPLE_W];
      if (s1_first_q) begin
        prev_eff[c] = cur[c];
      end else if (s1_col_q != last_col_q) begin
        prev_eff[c] = sample_q[c];
      end else begin
        prev_eff[c] = prev_q[c];
      end
    end
  end

  // Remember the last sample seen and the segment start held across a 2-px column
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_col_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sample_q[c] <= '0;
        prev_q[c]   <= '0;
      end
    end else begin
      last_col_q <= s1_col_q;
      for (int c = 0; c < NUM_CH; c++) begin
        sample_q[c] <= cur[c];
        prev_q[c]   <= prev_eff[c];
      end
    end
  end

  // A channel hits when the line lies on the vertical segment between prev and cur
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      lo[c]  = (cur[c] < prev_eff[c]) ? cur[c] : prev_eff[c];
      hi[c]  = (cur[c] < prev_eff[c]) ? prev_eff[c] : cur[c];
      hit[c] = s1_win_q && ch_enable_i[c] && (s1_yc_q >= lo[c]) && (s1_yc_q <= hi[c]);
    end
  end

`ifdef GRID_WAVE_DISPLAY_EN
  // Grid lines every 32 columns and every 32 sample rows
  assign grid_hit = s1_win_q &&
                    (((32'(s1_col_q) & 32'h1F) == 32'd0) || ((32'(s1_yc_q) & 32'h1F) == 32'd0));
`else
  assign grid_hit = 1'b0;
`endif

  // Lowest-index hitting channel wins; the grid (if any) only fills non-hit pixels
  always_comb begin
    color_d = grid_hit ? GRID_COLOR : 24'd0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (hit[c]) begin
        color_d = CH_COLORS[c*24 +: 24];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered outputs
  // ---------------------------------------------------------------------------

  // Output register; async reset blanks the pixel immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pixel_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      valid_pixel_q <= s1_win_q;
      rgb_q         <= s1_win_q ? color_d : 24'd0;
    end
  end

  assign valid_pixel_o = valid_pixel_q;
  assign r_o           = rgb_q[23:16];
  assign g_o           = rgb_q[15:8];
  assign b_o           = rgb_q[7:0];

  // ---------------------------------------------------------------------------
  // Bank-swap handshake
  // ---------------------------------------------------------------------------

  // Bank FSM state, display bank, ack pulse and dropped-frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      bank_q    <= 1'b0;
      buf_ack_q <= 1'b0;
      dropped_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      buf_ack_q <= buf_ack_d;
      dropped_q <= dropped_d;
    end
  end

  // Swap on frame_start when the writer is ready, otherwise count a dropped frame;
  // the ACK cycle ignores frame_start since frames are far apart
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    buf_ack_d = 1'b0;
    dropped_d = dropped_q;
    unique case (state_q)
      StRun: begin
        if (frame_start_i) begin
          if (bus.buf_ready) begin
            bank_d    = ~bank_q;
            buf_ack_d = 1'b1;
            state_d   = StAck;
          end else if (dropped_q != 8'hFF) begin
            dropped_d = dropped_q + 8'd1;
          end
        end
      end
      StAck: begin
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  assign bus.buf_ack      = buf_ack_q;
  assign dropped_frames_o = dropped_q;

endmodule

// File: tb/tb_wave_display_mc.sv
// Bench for wave_display_mc: a pixel-level model of the window/trace/priority rules
// and of the bank handshake, checked every cycle, plus hand-computed spot checks.
`timescale 1ns/1ps
module tb_wave_display_mc;
  localparam int NUM_CH   = 2;
  localparam int SAMPLE_W = 8;
  localparam int DEPTH_LG = 8;
  localparam int X0       = 256;
  localparam int Y0       = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x_i = '0;
  logic [9:0]  y_i = '0;
  logic        valid_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic [1:0]  ch_en = 2'b11;
  logic        valid_pixel;
  logic [7:0]  r, g, b, dropped;

  logic [7:0]  ram [NUM_CH][512];
  logic [23:0] colors [NUM_CH] = '{24'hFFFFFF, 24'h00FF00};

  int n_vec = 0;
  int n_err = 0;

  wave_display_mc_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DEPTH_LG(DEPTH_LG)) bus ();

  wave_display_mc dut (
    .clk              (clk),
    .rst              (rst),
    .x_i              (x_i),
    .y_i              (y_i),
    .valid_i          (valid_i),
    .frame_start_i    (frame_start_i),
    .ch_enable_i      (ch_en),
    .bus              (bus),
    .valid_pixel_o    (valid_pixel),
    .r_o              (r),
    .g_o              (g),
    .b_o              (b),
    .dropped_frames_o (dropped)
  );

  always #5 clk = ~clk;

  // Synchronous sample RAMs, one per channel, sharing the address
  always @(posedge clk) bus.read_value <= {ram[1][bus.read_address], ram[0][bus.read_address]};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected {valid_pixel, rgb} for one raster position, from the drawing rules
  function automatic logic [24:0] model_pix(input logic [10:0] xx, input logic [9:0] yy,
                                            input logic vv, input logic bk,
                                            input logic [1:0] en);
    int xr, yr, col, yc, cur, prv, lo, hi;
    logic [23:0] rgb;
    xr = int'(xx) - X0;
    yr = int'(yy) - Y0;
    if (!vv || xr < 0 || xr >= 512 || yr < 0 || yr >= 512) return 25'd0;
    col = xr / 2;
    yc  = yr / 2;
    rgb = 24'd0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      cur = int'(ram[c][int'(bk) * 256 + col]);
      prv = (col == 0) ? cur : int'(ram[c][int'(bk) * 256 + col - 1]);
      lo  = (cur < prv) ? cur : prv;
      hi  = (cur < prv) ? prv : cur;
      if (en[c] && yc >= lo && yc <= hi) rgb = colors[c];
    end
    return {1'b1, rgb};
  endfunction

  logic [24:0] e1 = '0, e2 = '0;
  logic        m_bank = 1'b0;
  logic        m_ack = 1'b0;
  int          m_drop = 0;

  // Model: 2-cycle pixel delay line and bank handshake
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e1 <= '0; e2 <= '0; m_bank <= 1'b0; m_ack <= 1'b0; m_drop <= 0;
    end else begin
      e2 <= e1;
      e1 <= model_pix(x_i, y_i, valid_i, m_bank, ch_en);
      m_ack <= 1'b0;
      if (frame_start_i && !m_ack) begin
        if (bus.buf_ready) begin
          m_bank <= ~m_bank;
          m_ack  <= 1'b1;
        end else if (m_drop < 255) begin
          m_drop <= m_drop + 1;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    check("cmp_valid_pixel", 32'(valid_pixel), 32'(e2[24]));
    check("cmp_rgb", {8'd0, r, g, b}, {8'd0, e2[23:0]});
    check("cmp_buf_ack", 32'(bus.buf_ack), 32'(m_ack));
    check("cmp_dropped", 32'(dropped), m_drop);
    check("cmp_bank", 32'(bus.read_address[DEPTH_LG]), 32'(m_bank));
  end

  task automatic drive(input int xx, input int yy, input logic v);
    @(posedge clk);
    #1;
    x_i = 11'(xx); y_i = 10'(yy); valid_i = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 1'b0);
  endtask

  task automatic scan(input int yy);
    for (int xx = X0 - 2; xx <= X0 + 513; xx++) drive(xx, yy, 1'b1);
    idle(3);
  endtask

  // Scan a line up to xt, hold there, and check the pixel 2 clocks later
  task automatic probe(input int yy, input int xt, input logic exp_vp,
                       input logic [23:0] exp_rgb, input string nm);
    for (int xx = X0 - 2; xx <= xt; xx++) drive(xx, yy, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check({nm, "_vp"}, 32'(valid_pixel), 32'(exp_vp));
    check({nm, "_rgb"}, {8'd0, r, g, b}, {8'd0, exp_rgb});
    idle(4);
  endtask

  task automatic pulse_fs();
    @(posedge clk); #1 frame_start_i = 1'b1;
    @(posedge clk); #1 frame_start_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.buf_ready = 1'b0;
    // Bank 0: both channels flat at 0x40; ch0 has a slope at col5/6 and a tall col255
    // Bank 1: ch0 flat at 0x20, ch1 flat at 0x30
    for (int a = 0; a < 256; a++) begin
      ram[0][a] = 8'h40; ram[1][a] = 8'h40;
      ram[0][256 + a] = 8'h20; ram[1][256 + a] = 8'h30;
    end
    ram[0][5]   = 8'd10;
    ram[0][6]   = 8'd20;
    ram[0][255] = 8'd200;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vp", 32'(valid_pixel), 32'd0);
    check("rst_rgb", {8'd0, r, g, b}, 32'd0);
    check("rst_ack", 32'(bus.buf_ack), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    #2 rst = 1'b0;
    idle(2);

    // Flat trace: 0x40 -> lines 128/129
    probe(128, X0 + 20, 1'b1, 24'hFFFFFF, "flat_on");
    probe(126, X0 + 20, 1'b1, 24'h000000, "flat_off");
    scan(128);
    scan(126);

    // Slope col5=10 -> col6=20: lines 20..41 lit at col6
    for (int yy = 18; yy <= 43; yy++) scan(yy);
    probe(20, X0 + 12, 1'b1, 24'hFFFFFF, "slope_lo");
    probe(41, X0 + 12, 1'b1, 24'hFFFFFF, "slope_hi");
    probe(42, X0 + 12, 1'b1, 24'h000000, "slope_above");
    probe(19, X0 + 12, 1'b1, 24'h000000, "slope_below");

    // Col0 must not join col255 (200) of the line above
    scan(200);
    probe(200, X0, 1'b1, 24'h000000, "no_wrap");

    // Priority and enables
    ch_en = 2'b10;
    probe(128, X0 + 20, 1'b1, 24'h00FF00, "en_ch1");
    ch_en = 2'b00;
    probe(128, X0 + 20, 1'b1, 24'h000000, "en_none");
    ch_en = 2'b11;
    probe(128, X0 + 20, 1'b1, 24'hFFFFFF, "prio_ch0");

    // Window edges
    probe(128, X0 - 1, 1'b0, 24'h000000, "edge_left_out");
    probe(128, X0, 1'b1, 24'hFFFFFF, "edge_left_in");
    probe(128, X0 + 512, 1'b0, 24'h000000, "edge_right_out");
    probe(512, X0 + 20, 1'b0, 24'h000000, "edge_bottom_out");
    probe(511, X0 + 20, 1'b1, 24'h000000, "edge_bottom_in");

    // Handshake: swap to bank 1, ack for exactly one cycle
    bus.buf_ready = 1'b1;
    pulse_fs();
    @(negedge clk);
    check("swap_ack_hi", 32'(bus.buf_ack), 32'd1);
    check("swap_bank", 32'(bus.read_address[DEPTH_LG]), 32'd1);
    @(negedge clk);
    check("swap_ack_lo", 32'(bus.buf_ack), 32'd0);
    idle(3);
    probe(64, X0 + 20, 1'b1, 24'hFFFFFF, "bank1_ch0");
    probe(96, X0 + 20, 1'b1, 24'h00FF00, "bank1_ch1");

    // frame_start held into the ACK cycle swaps only once
    @(posedge clk); #1 frame_start_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 frame_start_i = 1'b0;
    idle(2);
    check("ack_ignore_bank", 32'(bus.read_address[DEPTH_LG]), 32'd0);

    // buf_ready held across frames: one swap per frame_start
    repeat (3) begin
      pulse_fs();
      idle(3);
    end
    check("multi_swap_bank", 32'(bus.read_address[DEPTH_LG]), 32'd1);

    // Writer never ready: bank held, counter saturates
    bus.buf_ready = 1'b0;
    repeat (300) pulse_fs();
    idle(2);
    check("drop_sat", 32'(dropped), 32'hFF);
    check("drop_bank_held", 32'(bus.read_address[DEPTH_LG]), 32'd1);

    // Reset mid-raster clears everything at once
    for (int xx = X0 - 2; xx <= X0 + 100; xx++) drive(xx, 128, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("midrst_vp", 32'(valid_pixel), 32'd0);
    check("midrst_rgb", {8'd0, r, g, b}, 32'd0);
    check("midrst_ack", 32'(bus.buf_ack), 32'd0);
    check("midrst_dropped", 32'(dropped), 32'd0);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    idle(2);
    check("midrst_bank", 32'(bus.read_address[DEPTH_LG]), 32'd0);
    probe(128, X0 + 20, 1'b1, 24'hFFFFFF, "after_rst");
    scan(128);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
